// File: rtl/bht_pkg.sv
// rtl/bht_pkg.sv - shared types and counter update rule for branch_history_table
package bht_pkg;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_SNT = 2'b00;
    localparam cnt_t CNT_WNT = 2'b01;
    localparam cnt_t CNT_WT  = 2'b10;
    localparam cnt_t CNT_ST  = 2'b11;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    function automatic cnt_t next_cnt(input cnt_t cnt, input logic taken);
        cnt_t res;
        res = cnt;
        if (taken && (cnt != CNT_ST)) begin
            res = cnt + 2'b01;
        end else if (!taken && (cnt != CNT_SNT)) begin
            res = cnt - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_counter32.sv
// rtl/sat_counter32.sv - 32-bit saturating event counter with sync active-low clear
module sat_counter32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 32'd0;
        end else if (inc && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/branch_history_table.sv
// rtl/branch_history_table.sv - 2-bit counter branch predictor with clear engine; BHT_GSHARE_EN adds gshare indexing
module branch_history_table
    import bht_pkg::*;
#(
    parameter int   INDEX_BITS = 6,
    parameter cnt_t CNT_INIT   = CNT_WNT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           if_pc,
    output logic                  t_nt,
    output logic [INDEX_BITS-1:0] pred_idx,
    input  logic                  ex_valid,
    input  logic [INDEX_BITS-1:0] ex_idx,
    input  logic                  ex_taken,
    input  logic                  ex_pred,
    output logic                  init_done,
    output logic [31:0]           branch_cnt,
    output logic [31:0]           mispred_cnt
);

    localparam int ENTRIES = 2 ** INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] PTR_LAST = '1;

    cnt_t                  bht_mem [ENTRIES];
    state_t                state_q;
    state_t                state_d;
    logic [INDEX_BITS-1:0] ptr_q;
    logic                  clear_wr;
    logic                  train_wr;
    logic                  mispred_inc;
    logic                  unused_pc;

    always_comb begin
        state_d   = state_q;
        init_done = 1'b0;
        clear_wr  = 1'b0;
        train_wr  = 1'b0;
        case (state_q)
            CLEAR: begin
                clear_wr = 1'b1;
                if (ptr_q == PTR_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                init_done = 1'b1;
                train_wr  = ex_valid;
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (clear_wr) begin
                ptr_q <= ptr_q + INDEX_BITS'(1);
            end
        end
    end

    // Table has no reset of its own; the clear engine owns initialisation.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clear_wr) begin
                bht_mem[ptr_q] <= CNT_INIT;
            end else if (train_wr) begin
                bht_mem[ex_idx] <= next_cnt(bht_mem[ex_idx], ex_taken);
            end
        end
    end

`ifdef BHT_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr;

    always_ff @(posedge clk) begin
        if (!rst_n || (state_q == CLEAR)) begin
            ghr <= '0;
        end else if (ex_valid) begin
            ghr <= {ghr[INDEX_BITS-2:0], ex_taken};
        end
    end

    assign pred_idx = if_pc[INDEX_BITS+1:2] ^ ghr;
`else
    assign pred_idx = if_pc[INDEX_BITS+1:2];
`endif

    assign unused_pc   = ^{if_pc[31:INDEX_BITS+2], if_pc[1:0]};
    assign t_nt        = init_done & bht_mem[pred_idx][1];
    assign mispred_inc = train_wr & (ex_taken ^ ex_pred);

    sat_counter32 u_branch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (train_wr),
        .count (branch_cnt)
    );

    sat_counter32 u_mispred_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mispred_inc),
        .count (mispred_cnt)
    );

endmodule

// File: tb/tb_branch_history_table.sv
// tb/tb_branch_history_table.sv - self-checking bench for branch_history_table against a behavioural model
module tb_branch_history_table;

`ifdef BHT_GSHARE_EN
    localparam bit GSH = 1'b1;
`else
    localparam bit GSH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = 32'd0;
    logic        t_nt;
    logic [5:0]  pred_idx;
    logic        ex_valid = 1'b0;
    logic [5:0]  ex_idx = 6'd0;
    logic        ex_taken = 1'b0;
    logic        ex_pred = 1'b0;
    logic        init_done;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int passes = 0;
    int total  = 0;

    int          m_tbl [64];
    int          m_ghr;
    logic [31:0] m_branch;
    logic [31:0] m_mispred;

    always #5 clk = ~clk;

    branch_history_table dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_pc       (if_pc),
        .t_nt        (t_nt),
        .pred_idx    (pred_idx),
        .ex_valid    (ex_valid),
        .ex_idx      (ex_idx),
        .ex_taken    (ex_taken),
        .ex_pred     (ex_pred),
        .init_done   (init_done),
        .branch_cnt  (branch_cnt),
        .mispred_cnt (mispred_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pidx(input logic [31:0] pc);
        return ((pc >> 2) & 63) ^ (GSH ? m_ghr : 0);
    endfunction

    function automatic logic [31:0] pc_for(input int idx);
        return 32'((idx ^ (GSH ? m_ghr : 0)) << 2);
    endfunction

    task automatic model_update(input int idx, input bit taken, input bit pred);
        if (taken) m_tbl[idx] = (m_tbl[idx] == 3) ? 3 : m_tbl[idx] + 1;
        else       m_tbl[idx] = (m_tbl[idx] == 0) ? 0 : m_tbl[idx] - 1;
        if (m_branch != 32'hFFFF_FFFF) m_branch = m_branch + 1;
        if ((taken != pred) && (m_mispred != 32'hFFFF_FFFF)) m_mispred = m_mispred + 1;
        if (GSH) m_ghr = ((m_ghr << 1) | int'(taken)) & 63;
    endtask

    task automatic model_reset();
        m_branch  = 32'd0;
        m_mispred = 32'd0;
        m_ghr     = 0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        ex_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    // Runs the 64 clear cycles with junk branch traffic that must be ignored.
    task automatic clear_wait();
        for (int c = 1; c <= 64; c++) begin
            ex_valid = 1'($urandom_range(0, 1));
            ex_idx   = 6'($urandom_range(0, 63));
            ex_taken = 1'($urandom_range(0, 1));
            ex_pred  = 1'($urandom_range(0, 1));
            if_pc    = $urandom;
            #1;
            total++;
            if (init_done !== 1'b0 || t_nt !== 1'b0)
                $display("FAIL clear_cycle%0d init_done=%b t_nt=%b required 0 0", c, init_done, t_nt);
            else passes++;
            tick();
        end
        ex_valid = 1'b0;
        #1;
        total++;
        if (init_done !== 1'b1) $display("FAIL clear_done init_done=%b required 1", init_done);
        else passes++;
        total++;
        if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0)
            $display("FAIL clear_no_count branch=%0d mispred=%0d required 0 0", branch_cnt, mispred_cnt);
        else passes++;
        for (int i = 0; i < 64; i++) m_tbl[i] = 1;
    endtask

    task automatic train(input int idx, input bit taken, input bit pred);
        ex_valid = 1'b1;
        ex_idx   = 6'(idx);
        ex_taken = taken;
        ex_pred  = pred;
        tick();
        ex_valid = 1'b0;
        model_update(idx, taken, pred);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        ex_valid = 1'b1;
        ex_taken = 1'b1;
        tick();
        rst_n    = 1'b1;
        ex_valid = 1'b0;
        model_reset();
        total++;
        if (init_done !== 1'b0 || branch_cnt !== 32'd0 || mispred_cnt !== 32'd0)
            $display("FAIL reset_state init=%b branch=%0d mispred=%0d required 0 0 0",
                     init_done, branch_cnt, mispred_cnt);
        else passes++;
        clear_wait();
        for (int i = 0; i < 64; i++) begin
            if_pc = 32'(i << 2) | 32'($urandom_range(0, 3)) | ({$urandom} & 32'hFFFF_FF00);
            #1;
            total++;
            if (int'(pred_idx) !== model_pidx(if_pc) || t_nt !== 1'b0)
                $display("FAIL reset_entry%0d pred_idx=%0d t_nt=%b required %0d 0",
                         i, pred_idx, t_nt, model_pidx(if_pc));
            else passes++;
        end
        train(7, 1'b1, 1'b0);
        if_pc = pc_for(7);
        #1;
        total++;
        if (t_nt !== 1'b1) $display("FAIL reset_weak_nt t_nt=%b required 1", t_nt);
        else passes++;
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 3; k++) train(5, 1'b1, 1'b0);
        if_pc = pc_for(5);
        #1;
        total++;
        if (t_nt !== 1'b1) $display("FAIL sat_strong_t t_nt=%b required 1", t_nt);
        else passes++;
        train(5, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            train(5, 1'b0, 1'b1);
            if_pc = pc_for(5);
            #1;
            total++;
            if (t_nt !== (m_tbl[5] >= 2))
                $display("FAIL sat_dec%0d t_nt=%b required %b", k, t_nt, (m_tbl[5] >= 2));
            else passes++;
        end
    endtask

    task automatic test_read_during_write();
        if_pc    = pc_for(3);
        ex_valid = 1'b1;
        ex_idx   = 6'd3;
        ex_taken = 1'b1;
        ex_pred  = 1'b0;
        #1;
        total++;
        if (t_nt !== 1'b0) $display("FAIL rdw_old t_nt=%b required 0", t_nt);
        else passes++;
        tick();
        ex_valid = 1'b0;
        model_update(3, 1'b1, 1'b0);
        if_pc = pc_for(3);
        #1;
        total++;
        if (t_nt !== 1'b1) $display("FAIL rdw_new t_nt=%b required 1", t_nt);
        else passes++;
    endtask

    task automatic test_counts();
        logic [9:0] mask;
        bit         tk;
        mask = 10'b1001010010;
        do_reset();
        clear_wait();
        for (int k = 0; k < 10; k++) begin
            tk = 1'($urandom_range(0, 1));
            train($urandom_range(0, 63), tk, tk ^ mask[k]);
        end
        total++;
        if (branch_cnt !== 32'd10 || branch_cnt !== m_branch)
            $display("FAIL cnt_branch got=%0d required %0d", branch_cnt, m_branch);
        else passes++;
        total++;
        if (mispred_cnt !== 32'd4 || mispred_cnt !== m_mispred)
            $display("FAIL cnt_mispred got=%0d required %0d", mispred_cnt, m_mispred);
        else passes++;
        @(negedge clk);
        force dut.u_branch_cnt.count = 32'hFFFF_FFFF;
        ex_valid = 1'b1;
        ex_idx   = 6'd12;
        ex_taken = 1'b1;
        ex_pred  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        release dut.u_branch_cnt.count;
        model_update(12, 1'b1, 1'b1);
        tick();
        ex_valid = 1'b0;
        model_update(12, 1'b1, 1'b1);
        m_branch = 32'hFFFF_FFFF;
        total++;
        if (branch_cnt !== 32'hFFFF_FFFF)
            $display("FAIL cnt_saturate got=%h required ffffffff", branch_cnt);
        else passes++;
        total++;
        if (mispred_cnt !== m_mispred)
            $display("FAIL cnt_mispred_hold got=%0d required %0d", mispred_cnt, m_mispred);
        else passes++;
    endtask

    task automatic test_random();
        int pidx;
        for (int n = 0; n < 400; n++) begin
            if_pc    = $urandom;
            ex_valid = 1'($urandom_range(0, 1));
            ex_idx   = 6'($urandom_range(0, 63));
            ex_taken = 1'($urandom_range(0, 1));
            ex_pred  = 1'($urandom_range(0, 1));
            #1;
            pidx = model_pidx(if_pc);
            total++;
            if (int'(pred_idx) !== pidx || t_nt !== (m_tbl[pidx] >= 2))
                $display("FAIL rand%0d pred_idx=%0d t_nt=%b required %0d %b",
                         n, pred_idx, t_nt, pidx, (m_tbl[pidx] >= 2));
            else passes++;
            tick();
            if (ex_valid) model_update(int'(ex_idx), ex_taken, ex_pred);
        end
        ex_valid = 1'b0;
        total++;
        if (branch_cnt !== m_branch || mispred_cnt !== m_mispred)
            $display("FAIL rand_counts branch=%0d mispred=%0d required %0d %0d",
                     branch_cnt, mispred_cnt, m_branch, m_mispred);
        else passes++;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) train(9, 1'b1, 1'b0);
        ex_valid = 1'b1;
        ex_idx   = 6'd9;
        ex_taken = 1'b0;
        ex_pred  = 1'b1;
        rst_n    = 1'b0;
        tick();
        rst_n    = 1'b1;
        ex_valid = 1'b0;
        model_reset();
        total++;
        if (init_done !== 1'b0 || branch_cnt !== 32'd0 || mispred_cnt !== 32'd0)
            $display("FAIL mid_run_reset init=%b branch=%0d mispred=%0d required 0 0 0",
                     init_done, branch_cnt, mispred_cnt);
        else passes++;
        clear_wait();
        if_pc = pc_for(9);
        #1;
        total++;
        if (t_nt !== 1'b0) $display("FAIL mid_run_recleared t_nt=%b required 0", t_nt);
        else passes++;
        do_reset();
        for (int c = 0; c < 30; c++) tick();
        do_reset();
        clear_wait();
    endtask

    task automatic test_gshare();
        do_reset();
        clear_wait();
        train(10, 1'b1, 1'b1);
        train(20, 1'b1, 1'b1);
        train(30, 1'b0, 1'b0);
        if_pc = 32'd0;
        #1;
        total++;
        if (pred_idx !== (GSH ? 6'd6 : 6'd0) || int'(pred_idx) !== model_pidx(if_pc))
            $display("FAIL gshare_idx pred_idx=%0d required %0d", pred_idx, (GSH ? 6 : 0));
        else passes++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", passes, total);
        $fatal(1);
    end

    initial begin
        model_reset();
        for (int i = 0; i < 64; i++) m_tbl[i] = 1;
        test_reset();
        test_saturate();
        test_read_during_write();
        test_counts();
        test_random();
        test_reset_mid();
        test_gshare();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
